accel_axis_display: RTL and testbench
=====================================

# accel_axis_display

Parametrised display back-end for the accelerometer path. Accepts simultaneous signed samples from CHANNELS axes, block-averages each axis over 2^AVG_LOG2 samples, and converts the axis chosen by `sel` into a signed decimal readout on DIGITS active-low seven-segment digits. A sequential double-dabble converter is used. It sits between the SPI sample source and the HEX outputs. It replaces fixed three-axis, unfiltered, hex-only display logic.

## Interface
- CHANNELS, 3, number of axes (≥1)
- WIDTH, 16, sample width, two's complement (≥4)
- AVG_LOG2, 2, log2 of samples per averaging block (0 = no averaging)
- DIGITS, 6, total display digits including sign digit (2..8)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sample_valid  in  1  one-cycle strobe; all channels carry a new sample
- sample_data  in  CHANNELS*WIDTH  channel k at [k*WIDTH +: WIDTH], signed
- sel  in  max(1,$clog2(CHANNELS))  channel to display; values ≥CHANNELS select channel 0
- avg_out  out  CHANNELS*WIDTH  latest block average per channel, signed
- hex_out  out  DIGITS*7  digit d at [7d +: 7], bits 6..0 = g,f,e,d,c,b,a, active low; digit 0 = least significant
- out_valid  out  1  one-cycle pulse when hex_out is updated
- busy  out  1  conversion in progress
- overflow  out  1  displayed magnitude saturated (held until next conversion)

## Operation
- Accumulators: one per channel, WIDTH+AVG_LOG2 bits, signed. Shared block counter of AVG_LOG2 bits.
- On sample_valid, each accumulator adds its sign-extended sample, and the counter increments.
- On the sample_valid that completes a block (counter = 2^AVG_LOG2−1):
  - avg_out[k] = (acc[k] + sample[k]) >>> AVG_LOG2, an arithmetic shift that floors toward −inf.
  - Accumulators and counter clear.
  - A conversion request is raised.
- Accumulation never stalls; `busy` does not block sample_valid.
- A conversion request is also raised when `sel` differs from its value at the last LOAD while in IDLE.
- FSM states:
  - IDLE → LOAD when a request is pending.
  - LOAD: latch avg_out[sel]. Magnitude = |value| in WIDTH bits; −2^(WIDTH−1) gives 2^(WIDTH−1). Latch the sign. Compare the magnitude with 10^(DIGITS−1)−1; if it is greater, substitute that limit and set the overflow flag. Clear the pending request. → SHIFT.
  - SHIFT: WIDTH cycles of double-dabble (add-3 on each BCD nibble ≥5, then shift left one bit) into (DIGITS−1) BCD nibbles. → DONE.
  - DONE: register hex_out, overflow, out_valid=1. → IDLE.
- Requests arriving while not in IDLE or LOAD set a single pending flag. At most one extra conversion follows, and it uses the avg_out and sel current at its LOAD.
- Digit encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Blank = 1111111, minus = 0111111.
- Leading-zero blanking: magnitude digits above the most significant nonzero digit are blank. Magnitude 0 shows "0" in digit 0.
- Digit DIGITS−1 is the sign digit: minus if the value is negative, blank otherwise. Zero is never negative.

## Timing
- Reset, applied on the clock edge with rst=1, clears:
  - accumulators, counter, avg_out = 0
  - hex_out: digit 0 = 1000000, all others 1111111
  - out_valid = 0, busy = 0, overflow = 0
  - FSM = IDLE, pending = 0, last-sel = 0
- Reset mid-conversion aborts it. No out_valid follows.
- Edge E0 captures the block-completing sample_valid and updates avg_out.
- Starting from IDLE:
  - LOAD at E1.
  - SHIFT at E2..E(WIDTH+1).
  - On E(WIDTH+2), hex_out and overflow update and out_valid rises for exactly one cycle.
  - Total latency is WIDTH+2 cycles (18 at defaults).
- busy is high from E1 through the cycle in which out_valid is high, and low otherwise.
- A sel change seen in IDLE at edge S gives LOAD at S+1 and out_valid at S+WIDTH+2.
- A back-to-back pending conversion enters LOAD on the edge after DONE.

## Test plan
- Reset: assert rst for 2 cycles → avg_out=0; hex_out = {1111111 ×5, 1000000}; out_valid, busy, overflow = 0.
- Positive average: sel=0; four strobes with ch0=85, ch1=120, ch2=160 → avg_out = 85/120/160. out_valid arrives exactly 18 cycles after the 4th strobe. Digits 5..0 = blank, blank, blank, blank, 0000000, 0010010.
- Negative and floor: ch0 samples −1, −2, −2, −2 → avg_out[0] = −2, display shows minus in digit 5 and "2" in digit 0. Four strobes of ch1=−55, then sel=1 while idle → minus, blanks, "55", no new samples needed.
- Extremes: four strobes of −32768 → magnitude shows "32768" with minus, overflow=0. With DIGITS=4, value 32767 → "999", overflow=1.
- Collision: during SHIFT, change sel and complete another block → exactly two out_valid pulses. The second uses the new sel and the new average.
- Reset mid-SHIFT → no out_valid, outputs return to their reset values, and the next block converts normally.

Source files
------------

// File: rtl/accel_axis_display.sv
// ============================================================================
// Module   : accel_axis_display
// Purpose  : Per-axis block averaging of accelerometer samples and signed
//            decimal seven-segment readout of one selected axis.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module accel_axis_display #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 16,
    parameter int AVG_LOG2 = 2,
    parameter int DIGITS   = 6
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            sample_valid,
    input  logic [CHANNELS*WIDTH-1:0]                       sample_data,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] sel,
    output logic [CHANNELS*WIDTH-1:0]                       avg_out,
    output logic [DIGITS*7-1:0]                             hex_out,
    output logic                                            out_valid,
    output logic                                            busy,
    output logic                                            overflow
);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam int c_selw  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_accw  = WIDTH + AVG_LOG2;
    localparam int c_cntw  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int c_nb    = DIGITS - 1;
    localparam int c_srw   = 4 * c_nb + WIDTH;
    localparam int c_bitw  = $clog2(WIDTH);
    localparam logic [c_cntw-1:0] c_cnt_last = c_cntw'((1 << AVG_LOG2) - 1);
    localparam logic [c_bitw-1:0] c_bit_last = c_bitw'(WIDTH - 1);
    localparam logic [63:0]       c_lim      = pow10(DIGITS - 1) - 64'd1;
    localparam logic [DIGITS*7-1:0] c_hex_rst = {{(DIGITS-1){7'b1111111}}, 7'b1000000};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [c_cntw-1:0]  r_cnt;
    logic               w_block_done;
    logic               w_req;
    logic               r_pend;
    logic [c_selw-1:0]  r_last_sel;
    logic [c_selw-1:0]  w_sel_eff;
    logic [WIDTH-1:0]   w_load_val;
    logic               w_neg;
    logic [WIDTH-1:0]   w_mag;
    logic               w_over;
    logic [WIDTH-1:0]   w_mag_sat;
    logic [c_srw-1:0]   r_sr;
    logic [c_srw-1:0]   w_sr_next;
    logic [c_bitw-1:0]  r_bit;
    logic               r_neg;
    logic               r_ovf_pend;
    logic [DIGITS*7-1:0] r_hex;
    logic               r_ovf;
    logic               r_out_valid;

    assign w_block_done = sample_valid && (r_cnt == c_cnt_last);

    // ------------------------------------------------------------------
    // Block averaging, one accumulator per axis
    // ------------------------------------------------------------------
    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        logic signed [WIDTH-1:0]  w_samp;
        logic signed [c_accw-1:0] w_sum;
        logic signed [c_accw-1:0] r_acc;
        logic signed [WIDTH-1:0]  r_avg;

        assign w_samp = sample_data[k*WIDTH +: WIDTH];
        assign w_sum  = r_acc + c_accw'(w_samp);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_acc <= '0;
                r_avg <= '0;
            end else if (sample_valid) begin
                if (w_block_done) begin
                    r_acc <= '0;
                    r_avg <= WIDTH'(w_sum >>> AVG_LOG2);
                end else begin
                    r_acc <= w_sum;
                end
            end
        end

        assign avg_out[k*WIDTH +: WIDTH] = r_avg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (sample_valid) begin
            r_cnt <= w_block_done ? '0 : r_cnt + c_cntw'(1);
        end
    end

    // ------------------------------------------------------------------
    // Selected value, magnitude and saturation
    // ------------------------------------------------------------------
    assign w_sel_eff  = (32'(sel) < 32'(CHANNELS)) ? sel : '0;
    assign w_load_val = avg_out[int'(w_sel_eff)*WIDTH +: WIDTH];
    assign w_neg      = w_load_val[WIDTH-1];
    // Negating the most negative value wraps to 2^(WIDTH-1), read unsigned.
    assign w_mag      = w_neg ? -w_load_val : w_load_val;
    assign w_over     = 64'(w_mag) > c_lim;
    assign w_mag_sat  = w_over ? c_lim[WIDTH-1:0] : w_mag;

    assign w_req = w_block_done || ((r_state == S_IDLE) && (sel != r_last_sel));

    function automatic logic [c_srw-1:0] dd_step(input logic [c_srw-1:0] sr);
        logic [c_srw-1:0] t;
        t = sr;
        for (int i = 0; i < c_nb; i++) begin
            if (t[WIDTH+4*i +: 4] >= 4'd5) t[WIDTH+4*i +: 4] = t[WIDTH+4*i +: 4] + 4'd3;
        end
        return {t[c_srw-2:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Digits above the leading nonzero digit stay blank; digit 0 always shows.
    function automatic logic [DIGITS*7-1:0] render(input logic [4*c_nb-1:0] bcd, input logic neg);
        logic [DIGITS*7-1:0] h;
        logic                seen;
        h    = '1;
        seen = 1'b0;
        for (int d = c_nb - 1; d >= 0; d--) begin
            if ((bcd[4*d +: 4] != 4'd0) || (d == 0)) seen = 1'b1;
            if (seen) h[7*d +: 7] = seg7(bcd[4*d +: 4]);
        end
        h[7*(DIGITS-1) +: 7] = neg ? 7'b0111111 : 7'b1111111;
        return h;
    endfunction

    assign w_sr_next = dd_step(r_sr);

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_pend) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_bit == c_bit_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = (r_pend || w_block_done) ? S_LOAD : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend      <= 1'b0;
            r_last_sel  <= '0;
            r_sr        <= '0;
            r_bit       <= '0;
            r_neg       <= 1'b0;
            r_ovf_pend  <= 1'b0;
            r_hex       <= c_hex_rst;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_state == S_LOAD) r_pend <= 1'b0;
            else if (w_req)        r_pend <= 1'b1;
            case (r_state)
                S_LOAD: begin
                    r_sr       <= {{(4*c_nb){1'b0}}, w_mag_sat};
                    r_bit      <= '0;
                    r_neg      <= w_neg;
                    r_ovf_pend <= w_over;
                    r_last_sel <= sel;
                end
                S_SHIFT: begin
                    r_sr  <= w_sr_next;
                    r_bit <= r_bit + c_bitw'(1);
                    // The final shift result is rendered directly on the same edge.
                    if (r_bit == c_bit_last) begin
                        r_hex       <= render(w_sr_next[c_srw-1 -: 4*c_nb], r_neg);
                        r_ovf       <= r_ovf_pend;
                        r_out_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hex_out   = r_hex;
    assign out_valid = r_out_valid;
    assign overflow  = r_ovf;
    assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_accel_axis_display.sv
// ============================================================================
// Module   : tb_accel_axis_display
// Purpose  : Scoreboard bench for accel_axis_display with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_accel_axis_display;

    localparam logic [6:0] BL = 7'b1111111, MN = 7'b0111111;
    localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100;
    localparam logic [6:0] D3 = 7'b0110000, D5 = 7'b0010010, D6 = 7'b0000010;
    localparam logic [6:0] D7 = 7'b1111000, D8 = 7'b0000000, D9 = 7'b0010000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_valid = 1'b0;
    logic        sv4 = 1'b0;
    logic [47:0] sample_data = '0;
    logic [1:0]  sel = 2'd0;

    logic [47:0] avg_out;
    logic [41:0] hex_out;
    logic        out_valid, busy, overflow;
    logic [47:0] avg4;
    logic [27:0] hex4;
    logic        ov4, busy4, ovf4;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [41:0] hex;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

    accel_axis_display #(.CHANNELS(3), .WIDTH(16), .AVG_LOG2(2), .DIGITS(6)) u_dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
        .sel(sel), .avg_out(avg_out), .hex_out(hex_out), .out_valid(out_valid),
        .busy(busy), .overflow(overflow)
    );

    accel_axis_display #(.CHANNELS(3), .WIDTH(16), .AVG_LOG2(0), .DIGITS(4)) u_dut4 (
        .clk(clk), .rst(rst), .sample_valid(sv4), .sample_data(sample_data),
        .sel(2'd0), .avg_out(avg4), .hex_out(hex4), .out_valid(ov4),
        .busy(busy4), .overflow(ovf4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every out_valid pulse must match the oldest expectation, including its cycle.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out_valid hex=%h ovf=%b cyc=%0d", hex_out, overflow, cyc);
            end else begin
                m_e = sb.pop_front();
                if (hex_out !== m_e.hex || overflow !== m_e.ovf || cyc != m_e.cyc) begin
                    failures++;
                    $display("FAIL display got hex=%h ovf=%b cyc=%0d expected hex=%h ovf=%b cyc=%0d",
                             hex_out, overflow, cyc, m_e.hex, m_e.ovf, m_e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic push(input logic [41:0] h, input logic o, input int c);
        exp_t e;
        e.hex = h;
        e.ovf = o;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic strobe(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        sample_data  = {c, b, a};
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic block(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        repeat (4) strobe(a, b, c);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL wait_idle timeout pending=%0d busy=%b", sb.size(), busy);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int e;
        int n;
        @(negedge clk);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_avg", avg_out, 0);
        chk("reset_hex", hex_out, {BL, BL, BL, BL, BL, D0});
        chk("reset_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ovf", overflow, 0);
        chk("reset_hex4", hex4, {BL, BL, BL, D0});

        // Positive average with exact latency and busy start
        block(16'd85, 16'd120, 16'd160);
        push({BL, BL, BL, BL, D8, D5}, 1'b0, cyc + 18);
        chk("avg_pos", avg_out, {16'd160, 16'd120, 16'd85});
        chk("busy_e0", busy, 0);
        @(negedge clk);
        chk("busy_e1", busy, 1);
        wait_idle();

        // Floor toward -inf, then a sel change with no new samples
        strobe(16'hFFFF, 16'hFFC9, 16'd0);
        repeat (3) strobe(16'hFFFE, 16'hFFC9, 16'd0);
        push({MN, BL, BL, BL, BL, D2}, 1'b0, cyc + 18);
        chk("avg_neg", avg_out, {16'd0, 16'hFFC9, 16'hFFFE});
        wait_idle();
        sel = 2'd1;
        push({MN, BL, BL, BL, D5, D5}, 1'b0, cyc + 19);
        wait_idle();

        // Extremes
        block(16'd0, 16'h8000, 16'h7FFF);
        push({MN, D3, D2, D7, D6, D8}, 1'b0, cyc + 18);
        chk("avg_ext", avg_out, {16'h7FFF, 16'h8000, 16'h0000});
        wait_idle();
        sel = 2'd2;
        push({BL, D3, D2, D7, D6, D7}, 1'b0, cyc + 19);
        wait_idle();

        // Four-digit instance saturates
        sample_data = {16'd0, 16'd0, 16'h7FFF};
        sv4 = 1'b1;
        @(negedge clk);
        sv4 = 1'b0;
        n = 0;
        while (!ov4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("dut4_valid", ov4, 1);
        chk("dut4_hex", hex4, {BL, D9, D9, D9});
        chk("dut4_ovf", ovf4, 1);

        // Collision: sel change and a second block during SHIFT
        block(16'd0, 16'd0, 16'd1000);
        e = cyc + 18;
        push({BL, BL, D1, D0, D0, D0}, 1'b0, e);
        repeat (3) @(negedge clk);
        sel = 2'd1;
        block(16'd0, 16'hFFF7, 16'd5);
        push({MN, BL, BL, BL, BL, D9}, 1'b0, e + 18);
        wait_idle();
        repeat (30) @(negedge clk);

        // Reset during SHIFT aborts the conversion
        block(16'd0, 16'd77, 16'd0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        sel = 2'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("abort_hex", hex_out, {BL, BL, BL, BL, BL, D0});
        chk("abort_avg", avg_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_ovf4", ovf4, 0);
        repeat (30) @(negedge clk);
        block(16'd123, 16'd0, 16'd0);
        push({BL, BL, BL, D1, D2, D3}, 1'b0, cyc + 18);
        wait_idle();

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
